reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter DATA_W, default 8, register width in bits; SHALL be supported for 1..64.
REQ-002 Parameter DEPTH, default 8, number of registers; SHALL be a power of two, 2..256.
REQ-003 Parameter ZERO_R0, default 0; 1 = register 0 is hardwired to zero.
REQ-004 Derived constant ADDR_W = clog2(DEPTH); SHALL NOT be overridable.
REQ-005 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 we  in  1  write enable.
REQ-008 waddr  in  ADDR_W  write register index.
REQ-009 wdata  in  DATA_W  write data.
REQ-010 raddr1 / raddr2  in  ADDR_W  read port indices.
REQ-011 rdata1 / rdata2  out  DATA_W  read port data.
REQ-012 iss_valid  in  1  scoreboard: destination issued, result pending.
REQ-013 iss_rd  in  ADDR_W  scoreboard destination index.
REQ-014 busy1 / busy2  out  1  pending-write flag of raddr1 / raddr2.
REQ-015 clr_req  in  1  single-cycle request to clear all registers.
REQ-016 clr_busy  out  1  high while clear sequence runs.

Function
REQ-017 Reads SHALL be combinational: rdataN = reg[raddrN], busyN = pend[raddrN], zero cycles latency.
REQ-018 Write SHALL commit on the rising edge when we=1 and clr_busy=0; visible on reads the following cycle.
REQ-019 pend[i] SHALL set on the edge when iss_valid=1 and iss_rd=i; SHALL clear on the edge when a write to i commits.
REQ-020 Simultaneous issue and write-commit to the same index: pend SHALL remain set (issue wins); register takes wdata.
REQ-021 ZERO_R0=1: reads of index 0 SHALL return 0, writes to 0 dropped, pend[0] SHALL never set.
REQ-022 Clear FSM states: IDLE, CLEAR. IDLE->CLEAR on clr_req=1; CLEAR->IDLE after index DEPTH-1 cleared.
REQ-023 Entering CLEAR SHALL zero all pend bits on the same edge; in CLEAR one register per cycle, index counter 0..DEPTH-1, SHALL be zeroed.
REQ-024 clr_busy SHALL be 1 for exactly DEPTH cycles starting the cycle after clr_req is sampled.
REQ-025 During CLEAR: we and iss_valid SHALL be ignored; clr_req SHALL be ignored; reads return current (partially cleared) contents.
REQ-026 Index counter SHALL wrap to 0 on return to IDLE; no out-of-range access for any DEPTH.

Reset
REQ-027 reset_n=0 SHALL immediately force all registers to 0, all pend to 0, FSM to IDLE, counter to 0, clr_busy=0.
REQ-028 Reset asserted mid-CLEAR SHALL abort the sequence; after release the block SHALL be in IDLE with all registers 0.
REQ-029 rdata1/2, busy1/2 SHALL read 0 during and after reset until first write/issue.

Configuration
REQ-030 Macro REG_BANK_BYPASS_EN defined: when we=1, clr_busy=0 and waddr==raddrN (and not suppressed by ZERO_R0), rdataN SHALL return wdata and busyN SHALL return 0 in the same cycle.
REQ-031 REG_BANK_BYPASS_EN undefined: no forwarding; rdataN reflects stored value only, new data visible next cycle.

Structure
REQ-032 Package reg_bank_pkg SHALL hold the clear-FSM state enum (IDLE, CLEAR) and default constants for DATA_W, DEPTH.
REQ-033 Clear FSM and index counter SHALL be a sub-module reg_bank_clr_seq (outputs clr_busy, clr_idx, clr_we); storage, scoreboard and read muxes stay in reg_bank.

Verification
REQ-034 Reset then write 0xA5 to r3, read raddr1=3 next cycle -> rdata1=0xA5, busy1=0.
REQ-035 Issue iss_rd=5, then write r5=0x3C two cycles later -> busy flag on r5 =1 for two cycles, then 0 with rdata=0x3C.
REQ-036 Same edge iss_valid/iss_rd=2 and we/waddr=2/0x11 -> r2=0x11, busy for r2 =1.
REQ-037 Fill all 8 registers, pulse clr_req -> clr_busy high exactly 8 cycles, write to r1 during CLEAR dropped, all reads 0 afterward.
REQ-038 With REG_BANK_BYPASS_EN: we=1, waddr=raddr1=4, wdata=0x77 -> rdata1=0x77 same cycle; without macro, old value then 0x77 next cycle.
REQ-039 ZERO_R0=1: write 0xFF to r0, issue r0 -> rdata=0, busy=0; reset_n pulsed at clear index 3 -> IDLE, all registers 0.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and default sizes for the register bank and its clear sequencer.
package reg_bank_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_bank_clr_seq.sv
// Clear sequencer: on clr_req, walks every register index once, one per cycle.
module reg_bank_clr_seq
  import reg_bank_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              clr_we
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_e        state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE:  if (clr_req) state_nxt = CLEAR;
      CLEAR: begin
        // Requests arriving mid-sequence are dropped, not queued.
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_busy = (state == CLEAR);
  assign clr_we   = clr_busy;
  assign clr_idx  = idx;

endmodule

// File: rtl/reg_bank.sv
// Register bank with two combinational read ports, a pending-write scoreboard and a
// sequenced clear. Optional same-cycle write forwarding: define REG_BANK_BYPASS_EN.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int ZERO_R0 = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              busy1,
  output logic              busy2,
  input  logic              clr_req,
  output logic              clr_busy
);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pend;

  logic [ADDR_W-1:0] clr_idx;
  logic              clr_we;
  logic              wr_ok, iss_ok, clr_start;

  reg_bank_clr_seq #(.DEPTH(DEPTH)) u_clr_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_idx  (clr_idx),
    .clr_we   (clr_we)
  );

  // With ZERO_R0, index 0 is never written nor marked pending, so it always reads 0.
  assign wr_ok     = we        && !clr_busy && !((ZERO_R0 != 0) && (waddr  == '0));
  assign iss_ok    = iss_valid && !clr_busy && !((ZERO_R0 != 0) && (iss_rd == '0));
  assign clr_start = clr_req   && !clr_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regs <= '0;
    end else if (clr_we) begin
      regs[clr_idx] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
    end else if (clr_start) begin
      pend <= '0;
    end else begin
      if (wr_ok)  pend[waddr]  <= 1'b0;
      // Issue applied last so a same-edge issue to the written index keeps it pending.
      if (iss_ok) pend[iss_rd] <= 1'b1;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    rdata2 = regs[raddr2];
    busy1  = pend[raddr1];
    busy2  = pend[raddr2];
`ifdef REG_BANK_BYPASS_EN
    if (wr_ok && (waddr == raddr1)) begin
      rdata1 = wdata;
      busy1  = 1'b0;
    end
    if (wr_ok && (waddr == raddr2)) begin
      rdata2 = wdata;
      busy2  = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed scoreboard bench for reg_bank: default instance plus a ZERO_R0=1 instance.
module tb_reg_bank;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam int S_RD1 = 0, S_RD2 = 1, S_BZ1 = 2, S_BZ2 = 3, S_CB = 4,
                 S_ZRD1 = 5, S_ZBZ1 = 6, S_ZCB = 7;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, we, iss_valid, clr_req;
  logic [ADDR_W-1:0] waddr, raddr1, raddr2, iss_rd;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata1, rdata2, z_rdata1, z_rdata2;
  logic              busy1, busy2, clr_busy, z_busy1, z_busy2, z_clr_busy;

  reg_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZERO_R0(0)) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy1(busy1), .busy2(busy2),
    .clr_req(clr_req), .clr_busy(clr_busy)
  );

  reg_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZERO_R0(1)) dut_z (
    .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(z_rdata1), .rdata2(z_rdata2),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy1(z_busy1), .busy2(z_busy2),
    .clr_req(clr_req), .clr_busy(z_clr_busy)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input int sel, input logic [63:0] e);
    chk_t c;
    c.name = nm; c.sel = sel; c.exp = e;
    q.push_back(c);
  endtask

  function automatic logic [63:0] actual(input int sel);
    case (sel)
      S_RD1:   return 64'(rdata1);
      S_RD2:   return 64'(rdata2);
      S_BZ1:   return 64'(busy1);
      S_BZ2:   return 64'(busy2);
      S_CB:    return 64'(clr_busy);
      S_ZRD1:  return 64'(z_rdata1);
      S_ZBZ1:  return 64'(z_busy1);
      S_ZCB:   return 64'(z_clr_busy);
      default: return 64'hDEAD;
    endcase
  endfunction

  // Monitor: outputs are combinational, so every queued expectation is due this cycle.
  always @(negedge clk) begin : mon
    chk_t        c;
    logic [63:0] a;
    while (q.size() > 0) begin
      c = q.pop_front();
      a = actual(c.sel);
      n_total++;
      if (a === c.exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", c.name, a, c.exp);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    we = 1'b0; iss_valid = 1'b0; clr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; idle_inputs();
    waddr = '0; wdata = '0; iss_rd = '0; raddr1 = 3'd3; raddr2 = 3'd5;
    chk("rst_rd1", S_RD1, 0); chk("rst_rd2", S_RD2, 0);
    chk("rst_bz1", S_BZ1, 0); chk("rst_clrb", S_CB, 0);
    tick; tick;
    reset_n = 1'b1;
    chk("post_rst_rd1", S_RD1, 0); chk("post_rst_bz2", S_BZ2, 0);

    // Basic write, visible next cycle.
    we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
    tick;
    idle_inputs(); raddr1 = 3'd3;
    chk("w3_rd", S_RD1, 64'hA5); chk("w3_bz", S_BZ1, 0);

    // Issue r5, write it two cycles later.
    iss_valid = 1'b1; iss_rd = 3'd5;
    tick;
    idle_inputs(); raddr2 = 3'd5;
    chk("iss5_c1_bz", S_BZ2, 1);
    tick;
    we = 1'b1; waddr = 3'd5; wdata = 8'h3C;
    chk("iss5_c2_bz", S_BZ2, BYP ? 0 : 1);
    chk("iss5_c2_rd", S_RD2, BYP ? 64'h3C : 64'h00);
    tick;
    idle_inputs();
    chk("iss5_done_bz", S_BZ2, 0); chk("iss5_done_rd", S_RD2, 64'h3C);

    // Same-edge issue and write: issue wins, data lands.
    iss_valid = 1'b1; iss_rd = 3'd2; we = 1'b1; waddr = 3'd2; wdata = 8'h11;
    tick;
    idle_inputs(); raddr1 = 3'd2;
    chk("same_rd", S_RD1, 64'h11); chk("same_bz", S_BZ1, 1);

    // Forwarding (or not) of a write to the port being read.
    we = 1'b1; waddr = 3'd4; wdata = 8'h55;
    tick;
    we = 1'b1; waddr = 3'd4; wdata = 8'h77; raddr1 = 3'd4;
    chk("byp_rd", S_RD1, BYP ? 64'h77 : 64'h55); chk("byp_bz", S_BZ1, 0);
    tick;
    idle_inputs();
    chk("byp_next_rd", S_RD1, 64'h77);

    // Fill, mark r6 pending, then clear.
    for (int i = 0; i < DEPTH; i++) begin
      we = 1'b1; waddr = ADDR_W'(i); wdata = 8'(8'h10 + i);
      tick;
    end
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 3'd6;
    tick;
    idle_inputs(); raddr1 = 3'd6; raddr2 = 3'd7;
    chk("fill_bz6", S_BZ1, 1); chk("fill_rd7", S_RD2, 64'h17);
    clr_req = 1'b1;
    chk("clr_req_cb", S_CB, 0);
    tick;
    for (int k = 0; k < DEPTH; k++) begin
      idle_inputs();
      chk($sformatf("clr_cb_%0d", k), S_CB, 1);
      if (k == 0) chk("clr_pend6", S_BZ1, 0);
      if (k == 3) chk("clr_partial_rd7", S_RD2, 64'h17);
      if (k == 4) begin
        we = 1'b1; waddr = 3'd1; wdata = 8'hAA; raddr1 = 3'd1;
        clr_req = 1'b1; iss_valid = 1'b1; iss_rd = 3'd7;
        chk("clr_wr_drop_rd", S_RD1, 0); chk("clr_iss_drop_bz", S_BZ2, 0);
      end
      tick;
    end
    idle_inputs();
    chk("clr_end_cb", S_CB, 0);
    tick;
    chk("clr_end_cb2", S_CB, 0);
    for (int i = 0; i < DEPTH; i++) begin
      raddr1 = ADDR_W'(i); raddr2 = ADDR_W'(i);
      chk($sformatf("clr_rd_%0d", i), S_RD1, 0);
      chk($sformatf("clr_bz_%0d", i), S_BZ2, 0);
      tick;
    end

    // ZERO_R0 instance: r0 stays zero and never pending.
    we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr1 = 3'd0;
    chk("z_wr_rd_same", S_ZRD1, 0); chk("z_wr_bz_same", S_ZBZ1, 0);
    tick;
    idle_inputs(); iss_valid = 1'b1; iss_rd = 3'd0;
    tick;
    idle_inputs();
    chk("z_r0_rd", S_ZRD1, 0); chk("z_r0_bz", S_ZBZ1, 0);
    chk("r0_rd", S_RD1, 64'hFF); chk("r0_bz", S_BZ1, 1);

    // Reset in the middle of a clear sequence.
    we = 1'b1; waddr = 3'd3; wdata = 8'h33;
    tick;
    idle_inputs(); clr_req = 1'b1;
    tick;
    idle_inputs();
    tick; tick;
    chk("z_mid_cb", S_ZCB, 1);
    tick;
    reset_n = 1'b0; raddr1 = 3'd3;
    chk("abort_cb", S_CB, 0); chk("abort_zcb", S_ZCB, 0);
    chk("abort_rd3", S_RD1, 0); chk("abort_zrd3", S_ZRD1, 0);
    tick;
    reset_n = 1'b1;
    chk("rel_cb", S_CB, 0); chk("rel_zcb", S_ZCB, 0);
    tick;
    chk("rel_cb2", S_CB, 0);
    for (int i = 0; i < DEPTH; i++) begin
      raddr1 = ADDR_W'(i);
      chk($sformatf("rel_rd_%0d", i), S_RD1, 0);
      chk($sformatf("rel_zrd_%0d", i), S_ZRD1, 0);
      chk($sformatf("rel_bz_%0d", i), S_BZ1, 0);
      tick;
    end

    tick; tick;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
